// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Round-robin owner of one shared timer; programs the period,
//               sequences start/enable and returns a done pulse to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*PW-1:0] req_period,
    input  logic [NREQ-1:0]    cancel,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               spurious_irq,
    output logic               tmr_start,
    output logic               tmr_enable,
    output logic [PW-1:0]      tmr_period,
    input  logic               tmr_interrupt
);

    localparam int          c_iw   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned c_nreq = NREQ;
    localparam logic [NREQ-1:0] c_one = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_iw-1:0]   r_owner;
    logic [c_iw-1:0]   w_owner_nxt;
    logic [c_iw-1:0]   r_rr_ptr;
    logic [c_iw-1:0]   w_rr_nxt;
    logic [c_iw-1:0]   w_pick;
    logic              w_found;
    logic [NREQ-1:0]   w_pick_oh;
    logic [NREQ-1:0]   w_owner_oh;
    logic [PW-1:0]     w_pick_period;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   w_done_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_spur;
    logic              w_spur_nxt;
    logic              r_start;
    logic              w_start_nxt;
    logic              r_enable;
    logic              w_enable_nxt;
    logic [PW-1:0]     r_period;
    logic [PW-1:0]     w_period_nxt;
    logic              w_abort;

    // Index arithmetic modulo NREQ, valid for non-power-of-two NREQ too.
    function automatic logic [c_iw-1:0] wrap_add(input logic [c_iw-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= c_nreq) begin
            sum = sum - c_nreq;
        end
        return sum[c_iw-1:0];
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned i = 0; i < c_nreq; i++) begin
            if (!w_found && req[wrap_add(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_rr_ptr, i);
            end
        end
    end

    always_comb begin
        w_pick_period = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == c_iw'(i)) begin
                w_pick_period = req_period[i*PW +: PW];
            end
        end
    end

    assign w_pick_oh  = c_one << w_pick;
    assign w_owner_oh = c_one << r_owner;
    assign w_abort    = cancel[r_owner] | ~req[r_owner];

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_nxt     = r_rr_ptr;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_start_nxt  = 1'b0;
        w_enable_nxt = 1'b0;
        w_period_nxt = r_period;
        w_spur_nxt   = r_spur;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (tmr_interrupt) begin
                    w_spur_nxt = 1'b1;
                end
                if (w_found) begin
                    w_state_nxt  = S_LOAD;
                    w_owner_nxt  = w_pick;
                    w_rr_nxt     = wrap_add(w_pick, 1);
                    w_grant_nxt  = w_pick_oh;
                    w_period_nxt = w_pick_period;
                end
            end
            S_LOAD: begin
                // Start/enable stay low for this cycle so the timer count clears.
                if (w_abort) begin
                    w_state_nxt = S_ABORT;
                    w_grant_nxt = '0;
                end else if (r_period == '0) begin
                    w_state_nxt = S_DONE;
                    w_grant_nxt = '0;
                    w_done_nxt  = w_owner_oh;
                end else begin
                    w_state_nxt  = S_RUN;
                    w_start_nxt  = 1'b1;
                    w_enable_nxt = 1'b1;
                end
            end
            S_RUN: begin
                // An abort request beats a coincident expiry.
                if (w_abort) begin
                    w_state_nxt = S_ABORT;
                    w_grant_nxt = '0;
                end else if (tmr_interrupt) begin
                    w_state_nxt = S_DONE;
                    w_grant_nxt = '0;
                    w_done_nxt  = w_owner_oh;
                end else begin
                    w_start_nxt  = 1'b1;
                    w_enable_nxt = 1'b1;
                end
            end
            S_DONE, S_ABORT: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_spur   <= 1'b0;
            r_start  <= 1'b0;
            r_enable <= 1'b0;
            r_period <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_spur   <= w_spur_nxt;
            r_start  <= w_start_nxt;
            r_enable <= w_enable_nxt;
            r_period <= w_period_nxt;
        end
    end

    assign grant        = r_grant;
    assign done         = r_done;
    assign busy         = r_busy;
    assign spurious_irq = r_spur;
    assign tmr_start    = r_start;
    assign tmr_enable   = r_enable;
    assign tmr_period   = r_period;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Directed scoreboard bench for timer_arbiter (NREQ=4, PW=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int K_GRANT = 0;
    localparam int K_EN    = 1;
    localparam int K_DONE  = 2;
    localparam int K_ABORT = 3;

    typedef struct {
        int          kind;
        logic [3:0]  val;
        logic [15:0] per;
        int          cyc;
    } ev_t;

    typedef struct {
        string       nm;
        int          cyc;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic        sp;
        logic        st;
        logic        en;
        logic [15:0] per;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_period;
    logic [3:0]  cancel;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        spurious_irq;
    logic        tmr_start;
    logic        tmr_enable;
    logic [15:0] tmr_period;
    logic        tmr_interrupt;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          multi = 0;
    logic        fin_req = 1'b0;
    logic        fin_ack = 1'b0;
    logic [3:0]  prev_grant = 4'b0;
    logic        prev_en = 1'b0;
    ev_t         ev_q[$];
    snap_t       snap_q[$];

    timer_arbiter #(.NREQ(4), .PW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_period   (req_period),
        .cancel       (cancel),
        .grant        (grant),
        .done         (done),
        .busy         (busy),
        .spurious_irq (spurious_irq),
        .tmr_start    (tmr_start),
        .tmr_enable   (tmr_enable),
        .tmr_period   (tmr_period),
        .tmr_interrupt(tmr_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_GRANT: return "GRANT";
            K_EN:    return "ENABLE";
            K_DONE:  return "DONE";
            default: return "ABORT";
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic ev_check(input int k, input logic [3:0] v, input logic [15:0] p);
        ev_t e;
        n_cmp++;
        if (ev_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %s val=%b per=%0d at cyc %0d, required no event",
                     kname(k), v, p, cyc);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != k || e.val !== v || e.per !== p || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got %s val=%b per=%0d cyc=%0d, required %s val=%b per=%0d cyc=%0d",
                         kname(k), v, p, cyc, kname(e.kind), e.val, e.per, e.cyc);
            end
        end
    endtask

    task automatic snap_check(input snap_t s);
        n_cmp++;
        if (s.cyc != cyc) begin
            n_bad++;
            $display("FAIL snap %s: checked at cyc %0d, required cyc %0d", s.nm, cyc, s.cyc);
        end else if (grant !== s.g || done !== s.d || busy !== s.b || spurious_irq !== s.sp ||
                     tmr_start !== s.st || tmr_enable !== s.en || tmr_period !== s.per) begin
            n_bad++;
            $display("FAIL snap %s @%0d: got g=%b d=%b busy=%b spur=%b st=%b en=%b per=%0d, required g=%b d=%b busy=%b spur=%b st=%b en=%b per=%0d",
                     s.nm, cyc, grant, done, busy, spurious_irq, tmr_start, tmr_enable, tmr_period,
                     s.g, s.d, s.b, s.sp, s.st, s.en, s.per);
        end
    endtask

    always @(negedge clk) begin : monitor
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_check(snap_q.pop_front());
        end
        if (!rst) begin
            if ($countones(grant) > 1) multi++;
            if (done !== 4'b0)
                ev_check(K_DONE, done, 16'd0);
            else if (grant !== 4'b0 && prev_grant === 4'b0)
                ev_check(K_GRANT, grant, tmr_period);
            else if (grant === 4'b0 && prev_grant !== 4'b0)
                ev_check(K_ABORT, prev_grant, 16'd0);
            if (tmr_enable === 1'b1 && prev_en !== 1'b1)
                ev_check(K_EN, grant, 16'd0);
        end
        prev_grant = grant;
        prev_en    = tmr_enable;
        if (fin_req && !fin_ack) begin
            n_cmp++;
            if (ev_q.size() != 0 || snap_q.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: got %0d events and %0d snaps outstanding, required 0 and 0",
                         ev_q.size(), snap_q.size());
            end
            n_cmp++;
            if (multi != 0) begin
                n_bad++;
                $display("FAIL grant_onehot: got %0d multi-hot cycles, required 0", multi);
            end
            fin_ack = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_ev(input int k, input logic [3:0] v, input logic [15:0] p, input int at);
        ev_t e;
        e.kind = k; e.val = v; e.per = p; e.cyc = at;
        ev_q.push_back(e);
    endtask

    task automatic exp_snap(input string nm, input int at, input logic [3:0] g, input logic [3:0] d,
                            input logic b, input logic sp, input logic st, input logic en,
                            input logic [15:0] per);
        snap_t s;
        s.nm = nm; s.cyc = at; s.g = g; s.d = d; s.b = b; s.sp = sp;
        s.st = st; s.en = en; s.per = per;
        snap_q.push_back(s);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; cancel = 4'b0; tmr_interrupt = 1'b0;
        req_period = {16'd8, 16'd7, 16'd6, 16'd10};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state and single request (owner 0, period 10)
        exp_snap("reset", 3, 4'b0, 4'b0, 0, 0, 0, 0, 16'd0);
        wait_to(5);
        exp_ev(K_GRANT, 4'b0001, 16'd10, 6);
        exp_ev(K_EN,    4'b0001, 16'd0,  7);
        exp_ev(K_DONE,  4'b0001, 16'd0,  17);
        exp_snap("single_load", 6,  4'b0001, 4'b0,    1, 0, 0, 0, 16'd10);
        exp_snap("single_run",  7,  4'b0001, 4'b0,    1, 0, 1, 1, 16'd10);
        exp_snap("single_done", 17, 4'b0000, 4'b0001, 1, 0, 0, 0, 16'd10);
        exp_snap("single_idle", 19, 4'b0000, 4'b0000, 0, 0, 0, 0, 16'd10);
        req = 4'b0001;
        wait_to(16); tmr_interrupt = 1'b1;
        wait_to(17); tmr_interrupt = 1'b0;
        wait_to(18); req = 4'b0000;

        // reset, then full contention 0,1,2,3,0
        wait_to(22); rst = 1'b1;
        wait_to(23); rst = 1'b0;
        exp_snap("reset_clears", 23, 4'b0, 4'b0, 0, 0, 0, 0, 16'd0);
        req_period = {16'd8, 16'd7, 16'd6, 16'd5};
        for (int g = 0; g < 5; g++) begin
            exp_ev(K_GRANT, 4'b0001 << (g % 4), 16'(5 + (g % 4)), 26 + 5*g);
            exp_ev(K_EN,    4'b0001 << (g % 4), 16'd0,            27 + 5*g);
            exp_ev(K_DONE,  4'b0001 << (g % 4), 16'd0,            29 + 5*g);
        end
        exp_snap("contend_idle", 51, 4'b0, 4'b0, 0, 0, 0, 0, 16'd5);
        wait_to(25); req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_to(28 + 5*g); tmr_interrupt = 1'b1;
            wait_to(29 + 5*g); tmr_interrupt = 1'b0;
            wait_to(30 + 5*g);
            if (g == 4) begin
                req = 4'b0000;
            end else begin
                req[g % 4] = 1'b0;
                wait_to(31 + 5*g);
                req[g % 4] = 1'b1;
            end
        end

        // zero period on requester 2
        wait_to(53);
        req_period[32 +: 16] = 16'd0;
        exp_ev(K_GRANT, 4'b0100, 16'd0, 54);
        exp_ev(K_DONE,  4'b0100, 16'd0, 55);
        exp_snap("zero_load", 54, 4'b0100, 4'b0,    1, 0, 0, 0, 16'd0);
        exp_snap("zero_done", 55, 4'b0000, 4'b0100, 1, 0, 0, 0, 16'd0);
        exp_snap("zero_idle", 57, 4'b0000, 4'b0000, 0, 0, 0, 0, 16'd0);
        req = 4'b0100;
        wait_to(56); req = 4'b0000;

        // cancel: non-owner ignored, owner cancel beats interrupt
        wait_to(60);
        exp_ev(K_GRANT, 4'b0010, 16'd6, 61);
        exp_ev(K_EN,    4'b0010, 16'd0, 62);
        exp_ev(K_ABORT, 4'b0010, 16'd0, 65);
        exp_snap("cancel_other", 64, 4'b0010, 4'b0, 1, 0, 1, 1, 16'd6);
        exp_snap("cancel_abort", 65, 4'b0000, 4'b0, 1, 0, 0, 0, 16'd6);
        exp_snap("cancel_idle",  66, 4'b0000, 4'b0, 0, 0, 0, 0, 16'd6);
        req = 4'b0010;
        wait_to(63); cancel = 4'b1000;
        wait_to(64); cancel = 4'b0010; tmr_interrupt = 1'b1;
        wait_to(65); cancel = 4'b0000; tmr_interrupt = 1'b0; req = 4'b0000;

        // mid-run reset, then rr_ptr back at 0 and pending request kept
        wait_to(70);
        req_period[32 +: 16] = 16'd7;
        exp_ev(K_GRANT, 4'b0100, 16'd7, 71);
        exp_ev(K_EN,    4'b0100, 16'd0, 72);
        exp_ev(K_ABORT, 4'b0100, 16'd0, 75);
        exp_ev(K_GRANT, 4'b0001, 16'd5, 78);
        exp_ev(K_EN,    4'b0001, 16'd0, 79);
        exp_ev(K_DONE,  4'b0001, 16'd0, 81);
        exp_ev(K_GRANT, 4'b1000, 16'd8, 83);
        exp_ev(K_EN,    4'b1000, 16'd0, 84);
        exp_ev(K_DONE,  4'b1000, 16'd0, 86);
        exp_snap("midrun_rst", 75, 4'b0, 4'b0, 0, 0, 0, 0, 16'd0);
        exp_snap("pending_idle", 88, 4'b0, 4'b0, 0, 0, 0, 0, 16'd8);
        req = 4'b0100;
        wait_to(74); rst = 1'b1;
        wait_to(75); rst = 1'b0; req = 4'b0000;
        wait_to(77); req = 4'b1001;
        wait_to(80); tmr_interrupt = 1'b1;
        wait_to(81); tmr_interrupt = 1'b0;
        wait_to(82); req = 4'b1000;
        wait_to(85); tmr_interrupt = 1'b1;
        wait_to(86); tmr_interrupt = 1'b0;
        wait_to(87); req = 4'b0000;

        // spurious interrupt while idle is sticky until reset
        wait_to(89);
        exp_snap("spur_before", 90, 4'b0, 4'b0, 0, 0, 0, 0, 16'd8);
        exp_snap("spur_set",    92, 4'b0, 4'b0, 0, 1, 0, 0, 16'd8);
        exp_snap("spur_sticky", 96, 4'b0, 4'b0, 0, 1, 0, 0, 16'd8);
        exp_snap("spur_rst",    98, 4'b0, 4'b0, 0, 0, 0, 0, 16'd0);
        wait_to(91); tmr_interrupt = 1'b1;
        wait_to(92); tmr_interrupt = 1'b0;
        wait_to(97); rst = 1'b1;
        wait_to(98); rst = 1'b0;

        wait_to(100);
        fin_req = 1'b1;
        for (int i = 0; i < 5 && !fin_ack; i++) begin
            @(posedge clk);
            #1;
        end
        if (!fin_ack) begin
            $display("FAIL final_check: got no end-of-run check, required one");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
